// File: rtl/fifo1clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo1clk_ctrl
// Brief    : Single-clock FIFO controller for a dual-port RAM with a
//            two-cycle read latency, presenting a first-word-fall-through
//            valid/ready output through a three-entry register buffer.
//            Define FIFO1CLK_ERR_EN to build the sticky ovf/udf flags.
// Revision : 1.0  initial release
// ============================================================================
module fifo1clk_ctrl #(
    parameter int ADDRBIT   = 6,
    parameter int DEPTH     = 64,
    parameter int WIDTH     = 8,
    parameter int AFULL_LVL = 56
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [WIDTH-1:0]   wr_data,
    output logic               full,
    output logic               afull,
    output logic               rd_vld,
    input  logic               rd_rdy,
    output logic [WIDTH-1:0]   rd_data,
    output logic [ADDRBIT+1:0] level,
    output logic               ovf,
    output logic               udf,
    output logic               ram_wren,
    output logic [ADDRBIT-1:0] ram_wraddr,
    output logic [WIDTH-1:0]   ram_wdata,
    output logic [ADDRBIT-1:0] ram_rdaddr,
    input  logic [WIDTH-1:0]   ram_q
);

    localparam int                 c_CNT_W   = ADDRBIT + 1;
    localparam int                 c_LVL_W   = ADDRBIT + 2;
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AFULL   = c_CNT_W'(AFULL_LVL);
    localparam logic [ADDRBIT-1:0] c_PTR_ONE = ADDRBIT'(1);

    logic [ADDRBIT-1:0] r_wp;
    logic [ADDRBIT-1:0] r_rp;
    logic [c_CNT_W-1:0] r_ram_cnt;
    logic [1:0]         r_pipe;
    logic [WIDTH-1:0]   r_ob [3];
    logic [1:0]         r_ob_cnt;
    logic               r_full;
    logic               r_afull;
    logic [c_LVL_W-1:0] r_level;

    logic               w_wr_acc;
    logic               w_pop;
    logic               w_fetch;
    logic [2:0]         w_inflight;
    logic [c_CNT_W-1:0] w_ram_cnt_nxt;
    logic [1:0]         w_pipe_nxt;
    logic [1:0]         w_ob_cnt_nxt;
    logic [1:0]         w_ob_wr_idx;
    logic [c_LVL_W-1:0] w_level_nxt;

    // Gating with rst_n keeps the RAM write strobe quiet while reset is held.
    assign w_wr_acc   = rst_n & wr_en & ~r_full & ~flush;
    assign w_pop      = (r_ob_cnt != 2'd0) & rd_rdy;
    assign w_inflight = 3'(r_ob_cnt) + 3'(r_pipe[0]) + 3'(r_pipe[1]);
    // Only fetch if the word is guaranteed a free obuf slot on arrival.
    assign w_fetch    = (r_ram_cnt != '0) && (w_inflight < (3'd3 + 3'(w_pop)));

    assign w_ram_cnt_nxt = r_ram_cnt + c_CNT_W'(w_wr_acc) - c_CNT_W'(w_fetch);
    assign w_pipe_nxt    = {r_pipe[0], w_fetch};
    assign w_ob_cnt_nxt  = r_ob_cnt + 2'(r_pipe[1]) - 2'(w_pop);
    assign w_ob_wr_idx   = r_ob_cnt - 2'(w_pop);
    assign w_level_nxt   = c_LVL_W'(w_ram_cnt_nxt) + c_LVL_W'(w_pipe_nxt[0])
                         + c_LVL_W'(w_pipe_nxt[1]) + c_LVL_W'(w_ob_cnt_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_ram_cnt <= '0;
            r_pipe    <= '0;
            r_ob_cnt  <= '0;
            r_full    <= 1'b0;
            r_afull   <= 1'b0;
            r_level   <= '0;
            for (int i = 0; i < 3; i++) r_ob[i] <= '0;
        end else if (flush) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_ram_cnt <= '0;
            r_pipe    <= '0;
            r_ob_cnt  <= '0;
            r_full    <= 1'b0;
            r_afull   <= 1'b0;
            r_level   <= '0;
            for (int i = 0; i < 3; i++) r_ob[i] <= '0;
        end else begin
            if (w_wr_acc) r_wp <= r_wp + c_PTR_ONE;
            if (w_fetch)  r_rp <= r_rp + c_PTR_ONE;
            r_ram_cnt <= w_ram_cnt_nxt;
            r_pipe    <= w_pipe_nxt;
            r_ob_cnt  <= w_ob_cnt_nxt;
            r_full    <= (w_ram_cnt_nxt == c_DEPTH);
            r_afull   <= (w_ram_cnt_nxt >= c_AFULL);
            r_level   <= w_level_nxt;
            if (w_pop) begin
                r_ob[0] <= r_ob[1];
                r_ob[1] <= r_ob[2];
            end
            // Arriving word lands behind the post-pop tail; overrides the shift.
            for (int i = 0; i < 3; i++) begin
                if (r_pipe[1] && (w_ob_wr_idx == 2'(i))) r_ob[i] <= ram_q;
            end
        end
    end

`ifdef FIFO1CLK_ERR_EN
    logic r_ovf;
    logic r_udf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (wr_en && r_full)   r_ovf <= 1'b1;
            if (rd_rdy && !rd_vld) r_udf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
    assign udf = r_udf;
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

    assign full       = r_full;
    assign afull      = r_afull;
    assign rd_vld     = (r_ob_cnt != 2'd0);
    assign rd_data    = r_ob[0];
    assign level      = r_level;
    assign ram_wren   = w_wr_acc;
    assign ram_wraddr = r_wp;
    assign ram_wdata  = wr_data;
    assign ram_rdaddr = r_rp;

endmodule
`default_nettype wire

// File: tb/tb_fifo1clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo1clk_ctrl
// Brief    : Directed self-checking bench for fifo1clk_ctrl with a
//            behavioural two-cycle-latency dual-port RAM.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo1clk_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       afull;
    logic       rd_vld;
    logic       rd_rdy;
    logic [7:0] rd_data;
    logic [7:0] level;
    logic       ovf;
    logic       udf;
    logic       ram_wren;
    logic [5:0] ram_wraddr;
    logic [7:0] ram_wdata;
    logic [5:0] ram_rdaddr;
    logic [7:0] ram_q;

    logic [7:0] mem [64];
    logic [5:0] ram_ra;

    int checks   = 0;
    int failures = 0;
    logic exp_err;

    always #5 clk = ~clk;

    fifo1clk_ctrl #(
        .ADDRBIT   (6),
        .DEPTH     (64),
        .WIDTH     (8),
        .AFULL_LVL (56)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .afull      (afull),
        .rd_vld     (rd_vld),
        .rd_rdy     (rd_rdy),
        .rd_data    (rd_data),
        .level      (level),
        .ovf        (ovf),
        .udf        (udf),
        .ram_wren   (ram_wren),
        .ram_wraddr (ram_wraddr),
        .ram_wdata  (ram_wdata),
        .ram_rdaddr (ram_rdaddr),
        .ram_q      (ram_q)
    );

    // Registered address, registered data: q valid two cycles after address.
    always @(posedge clk) begin
        if (ram_wren) mem[ram_wraddr] <= ram_wdata;
        ram_ra <= ram_rdaddr;
        ram_q  <= mem[ram_ra];
    end

    task automatic test_reset;
        rst_n   = 1'b0;
        flush   = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'h77;
        rd_rdy  = 1'b0;
        #2;
        checks++; if (rd_vld !== 1'b0)   begin failures++; $display("FAIL reset_rd_vld got=%0h exp=0", rd_vld); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data); end
        checks++; if (level !== 8'd0)    begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (full !== 1'b0)     begin failures++; $display("FAIL reset_full got=%0h exp=0", full); end
        checks++; if (afull !== 1'b0)    begin failures++; $display("FAIL reset_afull got=%0h exp=0", afull); end
        checks++; if (ovf !== 1'b0)      begin failures++; $display("FAIL reset_ovf got=%0h exp=0", ovf); end
        checks++; if (udf !== 1'b0)      begin failures++; $display("FAIL reset_udf got=%0h exp=0", udf); end
        checks++; if (ram_wren !== 1'b0) begin failures++; $display("FAIL reset_ram_wren got=%0h exp=0", ram_wren); end
        checks++; if (ram_wraddr !== 6'd0) begin failures++; $display("FAIL reset_ram_wraddr got=%0d exp=0", ram_wraddr); end
        checks++; if (ram_rdaddr !== 6'd0) begin failures++; $display("FAIL reset_ram_rdaddr got=%0d exp=0", ram_rdaddr); end
        checks++; if (ram_wdata !== 8'h77) begin failures++; $display("FAIL reset_ram_wdata got=%0h exp=77", ram_wdata); end
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 1'b0;
    endtask

    task automatic test_single_word;
        logic       e_vld;
        logic [7:0] e_lvl;
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        rd_rdy  = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            e_vld = (k == 4);
            e_lvl = (k <= 4) ? 8'd1 : 8'd0;
            checks++; if (rd_vld !== e_vld) begin failures++; $display("FAIL single_rd_vld cyc=%0d got=%0h exp=%0h", k, rd_vld, e_vld); end
            checks++; if (level !== e_lvl)  begin failures++; $display("FAIL single_level cyc=%0d got=%0d exp=%0d", k, level, e_lvl); end
            if (k == 4) begin
                checks++; if (rd_data !== 8'hA5) begin failures++; $display("FAIL single_rd_data got=%0h exp=a5", rd_data); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_streaming;
        int n    = 0;
        int last = 0;
        rd_rdy = 1'b1;
        for (int c = 0; c < 212; c++) begin
            if (rd_vld === 1'b1) begin
                checks++; if (rd_data !== 8'(n)) begin failures++; $display("FAIL stream_data idx=%0d got=%0h exp=%0h", n, rd_data, 8'(n)); end
                checks++;
                if (n == 0) begin
                    if (c != 4) begin failures++; $display("FAIL stream_first_pop got_cycle=%0d exp_cycle=4", c); end
                end else if (c != last + 1) begin
                    failures++; $display("FAIL stream_bubble idx=%0d got_cycle=%0d exp_cycle=%0d", n, c, last + 1);
                end
                last = c;
                n++;
            end
            wr_en   = (c < 200);
            wr_data = 8'(c);
            @(negedge clk);
        end
        wr_en = 1'b0;
        checks++; if (n != 200)       begin failures++; $display("FAIL stream_count got=%0d exp=200", n); end
        checks++; if (level !== 8'd0) begin failures++; $display("FAIL stream_level_end got=%0d exp=0", level); end
    endtask

    task automatic test_fill;
        int n = 0;
        rd_rdy = 1'b0;
        for (int c = 0; c < 70; c++) begin
            if (c == 58) begin checks++; if (afull !== 1'b0) begin failures++; $display("FAIL fill_afull_c58 got=%0h exp=0", afull); end end
            if (c == 59) begin checks++; if (afull !== 1'b1) begin failures++; $display("FAIL fill_afull_c59 got=%0h exp=1", afull); end end
            if (c == 66) begin checks++; if (full !== 1'b0)  begin failures++; $display("FAIL fill_full_c66 got=%0h exp=0", full); end end
            if (c == 67) begin
                checks++; if (full !== 1'b1)   begin failures++; $display("FAIL fill_full_c67 got=%0h exp=1", full); end
                checks++; if (level !== 8'd67) begin failures++; $display("FAIL fill_level_c67 got=%0d exp=67", level); end
            end
            wr_en   = 1'b1;
            wr_data = 8'(c);
            @(negedge clk);
        end
        wr_en = 1'b0;
        checks++; if (level !== 8'd67) begin failures++; $display("FAIL fill_level got=%0d exp=67", level); end
        checks++; if (full !== 1'b1)   begin failures++; $display("FAIL fill_full got=%0h exp=1", full); end
        checks++; if (ovf !== exp_err) begin failures++; $display("FAIL fill_ovf got=%0h exp=%0h", ovf, exp_err); end
        rd_rdy = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (rd_vld === 1'b1) begin
                checks++; if (rd_data !== 8'(n)) begin failures++; $display("FAIL drain_data idx=%0d got=%0h exp=%0h", n, rd_data, 8'(n)); end
                n++;
            end
            @(negedge clk);
        end
        checks++; if (n != 67)         begin failures++; $display("FAIL drain_count got=%0d exp=67", n); end
        checks++; if (level !== 8'd0)  begin failures++; $display("FAIL drain_level got=%0d exp=0", level); end
        checks++; if (full !== 1'b0)   begin failures++; $display("FAIL drain_full got=%0h exp=0", full); end
        checks++; if (afull !== 1'b0)  begin failures++; $display("FAIL drain_afull got=%0h exp=0", afull); end
    endtask

    task automatic test_underflow;
        wr_en  = 1'b0;
        rd_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL udf_rd_vld cyc=%0d got=%0h exp=0", k, rd_vld); end
            checks++; if (level !== 8'd0)  begin failures++; $display("FAIL udf_level cyc=%0d got=%0d exp=0", k, level); end
            @(negedge clk);
        end
        checks++; if (udf !== exp_err) begin failures++; $display("FAIL udf_flag got=%0h exp=%0h", udf, exp_err); end
    endtask

    task automatic test_flush;
        logic found = 1'b0;
        rd_rdy = 1'b0;
        for (int c = 0; c < 12; c++) begin
            wr_en   = 1'b1;
            wr_data = 8'h10 + 8'(c);
            @(negedge clk);
        end
        // Two pops restart fetching; dropping rd_rdy leaves two words in flight.
        wr_en  = 1'b0;
        rd_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rd_rdy = 1'b0;
        checks++; if (level !== 8'd10) begin failures++; $display("FAIL flush_pre_level got=%0d exp=10", level); end
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        @(negedge clk);
        flush = 1'b0;
        wr_en = 1'b0;
        checks++; if (ram_wraddr !== 6'd0) begin failures++; $display("FAIL flush_wraddr got=%0d exp=0", ram_wraddr); end
        checks++; if (ram_rdaddr !== 6'd0) begin failures++; $display("FAIL flush_rdaddr got=%0d exp=0", ram_rdaddr); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL flush_rd_vld cyc=%0d got=%0h exp=0", k, rd_vld); end
            checks++; if (level !== 8'd0)  begin failures++; $display("FAIL flush_level cyc=%0d got=%0d exp=0", k, level); end
            @(negedge clk);
        end
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        rd_rdy  = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (rd_vld === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!found) begin failures++; $display("FAIL flush_timeout got=no_word exp=word_3c"); end
        checks++; if (rd_data !== 8'h3C) begin failures++; $display("FAIL flush_next_word got=%0h exp=3c", rd_data); end
        @(negedge clk);
    endtask

    task automatic test_mid_reset;
        logic found = 1'b0;
        rd_rdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            wr_en   = 1'b1;
            wr_data = 8'h80 + 8'(c);
            @(negedge clk);
        end
        checks++; if (rd_vld !== 1'b1) begin failures++; $display("FAIL mrst_streaming got=%0h exp=1", rd_vld); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (rd_vld !== 1'b0)     begin failures++; $display("FAIL mrst_rd_vld got=%0h exp=0", rd_vld); end
        checks++; if (rd_data !== 8'h00)   begin failures++; $display("FAIL mrst_rd_data got=%0h exp=0", rd_data); end
        checks++; if (level !== 8'd0)      begin failures++; $display("FAIL mrst_level got=%0d exp=0", level); end
        checks++; if (ram_wren !== 1'b0)   begin failures++; $display("FAIL mrst_ram_wren got=%0h exp=0", ram_wren); end
        checks++; if (ram_wraddr !== 6'd0) begin failures++; $display("FAIL mrst_wraddr got=%0d exp=0", ram_wraddr); end
        checks++; if (ram_rdaddr !== 6'd0) begin failures++; $display("FAIL mrst_rdaddr got=%0d exp=0", ram_rdaddr); end
        checks++; if (udf !== 1'b0)        begin failures++; $display("FAIL mrst_udf got=%0h exp=0", udf); end
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL mrst_stale cyc=%0d got=%0h exp=0", k, rd_vld); end
            @(negedge clk);
        end
        wr_en   = 1'b1;
        wr_data = 8'h5A;
        @(negedge clk);
        wr_en = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (rd_vld === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!found) begin failures++; $display("FAIL mrst_timeout got=no_word exp=word_5a"); end
        checks++; if (rd_data !== 8'h5A) begin failures++; $display("FAIL mrst_next_word got=%0h exp=5a", rd_data); end
        @(negedge clk);
    endtask

    initial begin
`ifdef FIFO1CLK_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        ram_ra = 6'd0;
        ram_q  = 8'h00;
        test_reset();
        test_single_word();
        test_streaming();
        test_fill();
        test_underflow();
        test_flush();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
